// File: rtl/operand_entry.sv
// Keypad operand entry: one digit per key press into a BCD/binary operand, with an ASCII echo per digit.
// Optional macro BKSP_EN adds a backspace input and a RECALC state that rebuilds the binary value.
module operand_entry #(
    parameter int DIGITS = 4,
    parameter int BIN_W  = 14
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [3:0]          digit_in,
    input  logic                digit_valid,
    input  logic                enter,
    input  logic                clr,
`ifdef BKSP_EN
    input  logic                bksp,
`endif
    output logic [4*DIGITS-1:0] bcd_out,
    output logic [BIN_W-1:0]    bin_out,
    output logic [3:0]          count,
    output logic                full,
    output logic [7:0]          echo_char,
    output logic                echo_valid,
    input  logic                echo_ready,
    output logic                operand_valid,
    output logic [BIN_W-1:0]    operand_bin
);
    typedef enum logic [1:0] {
        IDLE, ENTRY,
`ifdef BKSP_EN
        RECALC,
`endif
        ECHO
    } state_t;

    localparam logic [3:0] DIG_MAX = 4'(DIGITS);

    state_t              state_q, state_d;
    logic                dv_q;
    logic                pend_q, pend_d;
    logic [4*DIGITS-1:0] bcd_q, bcd_d;
    logic [BIN_W-1:0]    bin_q, bin_d, opb_q, opb_d;
    logic [3:0]          cnt_q, cnt_d;
    logic [7:0]          ech_q, ech_d;
    logic                ev_q, ev_d, opv_q, opv_d;
    logic                press, deliver;
`ifdef BKSP_EN
    logic [3:0]          rc_q, rc_d;
    logic [4*DIGITS-1:0] rc_sh;
    // rc_q counts remaining digits; the next one to fold in sits at nibble rc_q-1
    assign rc_sh = bcd_q >> {rc_q - 4'd1, 2'b00};
`endif

    function automatic logic [BIN_W-1:0] mac10(input logic [BIN_W-1:0] a, input logic [3:0] d);
        return (a << 3) + (a << 1) + BIN_W'(d);
    endfunction

    assign press = digit_valid & ~dv_q;

    always_comb begin
        state_d = state_q;
        pend_d  = pend_q;
        bcd_d   = bcd_q;
        bin_d   = bin_q;
        cnt_d   = cnt_q;
        ech_d   = ech_q;
        ev_d    = ev_q;
        opv_d   = 1'b0;
        opb_d   = opb_q;
        deliver = 1'b0;
`ifdef BKSP_EN
        rc_d    = rc_q;
`endif
        if (clr) begin
            state_d = IDLE;
            pend_d  = 1'b0;
            bcd_d   = '0;
            bin_d   = '0;
            cnt_d   = '0;
            ev_d    = 1'b0;
        end else begin
            case (state_q)
                IDLE, ENTRY: begin
                    if (enter) begin
                        deliver = 1'b1;
`ifdef BKSP_EN
                    end else if (bksp && state_q == ENTRY && cnt_q != 4'd0) begin
                        bcd_d = bcd_q >> 4;
                        bin_d = '0;
                        cnt_d = cnt_q - 4'd1;
                        rc_d  = cnt_q - 4'd1;
                        if (cnt_q == 4'd1) begin
                            ech_d   = 8'h08;
                            ev_d    = 1'b1;
                            state_d = ECHO;
                        end else begin
                            state_d = RECALC;
                        end
`endif
                    end else if (press && digit_in <= 4'd9 && cnt_q < DIG_MAX) begin
                        bcd_d   = (bcd_q << 4) | (4*DIGITS)'(digit_in);
                        bin_d   = mac10(bin_q, digit_in);
                        cnt_d   = cnt_q + 4'd1;
                        ech_d   = 8'h30 + {4'h0, digit_in};
                        ev_d    = 1'b1;
                        state_d = ECHO;
                    end
                end
                ECHO: begin
                    // an enter coinciding with the handshake still counts as pending
                    if (echo_ready) begin
                        ev_d = 1'b0;
                        if (pend_q || enter) deliver = 1'b1;
                        else state_d = (cnt_q == 4'd0) ? IDLE : ENTRY;
                    end else if (enter) begin
                        pend_d = 1'b1;
                    end
                end
`ifdef BKSP_EN
                RECALC: begin
                    bin_d = mac10(bin_q, rc_sh[3:0]);
                    rc_d  = rc_q - 4'd1;
                    if (rc_q == 4'd1) begin
                        ech_d   = 8'h08;
                        ev_d    = 1'b1;
                        state_d = ECHO;
                    end
                end
`endif
                default: state_d = IDLE;
            endcase
            if (deliver) begin
                opv_d   = 1'b1;
                opb_d   = bin_q;
                bcd_d   = '0;
                bin_d   = '0;
                cnt_d   = '0;
                pend_d  = 1'b0;
                state_d = IDLE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            dv_q    <= 1'b0;
            pend_q  <= 1'b0;
            bcd_q   <= '0;
            bin_q   <= '0;
            cnt_q   <= '0;
            ech_q   <= '0;
            ev_q    <= 1'b0;
            opv_q   <= 1'b0;
            opb_q   <= '0;
`ifdef BKSP_EN
            rc_q    <= '0;
`endif
        end else begin
            state_q <= state_d;
            dv_q    <= digit_valid;
            pend_q  <= pend_d;
            bcd_q   <= bcd_d;
            bin_q   <= bin_d;
            cnt_q   <= cnt_d;
            ech_q   <= ech_d;
            ev_q    <= ev_d;
            opv_q   <= opv_d;
            opb_q   <= opb_d;
`ifdef BKSP_EN
            rc_q    <= rc_d;
`endif
        end
    end

    assign bcd_out       = bcd_q;
    assign bin_out       = bin_q;
    assign count         = cnt_q;
    assign full          = (cnt_q == DIG_MAX);
    assign echo_char     = ech_q;
    assign echo_valid    = ev_q;
    assign operand_valid = opv_q;
    assign operand_bin   = opb_q;
endmodule

// File: tb/tb_operand_entry.sv
// Directed bench for operand_entry (DIGITS=4, BIN_W=14): press/echo, full, enter, pending enter, clr.
module tb_operand_entry;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [3:0]  digit_in = 4'd0;
    logic        digit_valid = 1'b0;
    logic        enter = 1'b0;
    logic        clr = 1'b0;
    logic        echo_ready = 1'b0;
`ifdef BKSP_EN
    logic        bksp = 1'b0;
`endif
    logic [15:0] bcd_out;
    logic [13:0] bin_out;
    logic [3:0]  count;
    logic        full;
    logic [7:0]  echo_char;
    logic        echo_valid;
    logic        operand_valid;
    logic [13:0] operand_bin;

    int errors = 0;
    int checks = 0;
    int hs_cnt = 0;

    operand_entry #(.DIGITS(4), .BIN_W(14)) dut (
        .clk(clk), .rst(rst), .digit_in(digit_in), .digit_valid(digit_valid),
        .enter(enter), .clr(clr),
`ifdef BKSP_EN
        .bksp(bksp),
`endif
        .bcd_out(bcd_out), .bin_out(bin_out), .count(count), .full(full),
        .echo_char(echo_char), .echo_valid(echo_valid), .echo_ready(echo_ready),
        .operand_valid(operand_valid), .operand_bin(operand_bin)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (rst && echo_valid && echo_ready) hs_cnt <= hs_cnt + 1;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_clr();
        clr = 1'b1;
        tick();
        clr = 1'b0;
    endtask

    // Key held 5 sampled cycles; echo_ready (if enabled) raised 2 cycles after the echo appears.
    task automatic press_echo(input logic [3:0] d, input bit rdy, output bit ev, output logic [7:0] ch);
        digit_in = d;
        digit_valid = 1'b1;
        tick();
        ev = echo_valid;
        ch = echo_char;
        tick();
        tick();
        echo_ready = rdy;
        tick();
        echo_ready = 1'b0;
        tick();
        digit_valid = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        bit ev;
        logic [7:0] ch;
        repeat (2) tick();
        checks++;
        if ({bcd_out, bin_out, count, full, echo_char, echo_valid, operand_valid, operand_bin} !== '0) begin
            errors++;
            $display("FAIL reset_init: got bcd=%h bin=%0d cnt=%0d ev=%b want all zero", bcd_out, bin_out, count, echo_valid);
        end
        rst = 1'b1;
        tick();
        press_echo(4'd5, 1'b1, ev, ch);
        press_echo(4'd7, 1'b1, ev, ch);
        checks++;
        if (bcd_out !== 16'h0057) begin
            errors++;
            $display("FAIL reset_pre_entry: got bcd=%h want 0057", bcd_out);
        end
        #3 rst = 1'b0;
        #1;
        checks++;
        if ({bcd_out, bin_out, count, full, echo_char, echo_valid, operand_valid, operand_bin} !== '0) begin
            errors++;
            $display("FAIL reset_async: got bcd=%h bin=%0d cnt=%0d want all zero", bcd_out, bin_out, count);
        end
        tick();
        rst = 1'b1;
        tick();
        checks++;
        if (count !== 4'd0 || echo_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: got cnt=%0d ev=%b want 0 0", count, echo_valid);
        end
    endtask

    task automatic test_digits();
        bit ev;
        logic [7:0] ch;
        int hs0;
        hs0 = hs_cnt;
        for (int i = 1; i <= 3; i++) begin
            press_echo(4'(i), 1'b1, ev, ch);
            checks++;
            if (ev !== 1'b1 || ch !== 8'h30 + 8'(i)) begin
                errors++;
                $display("FAIL digit_echo%0d: got ev=%b ch=%h want 1 %h", i, ev, ch, 8'h30 + 8'(i));
            end
        end
        checks++;
        if (hs_cnt - hs0 !== 3 || echo_valid !== 1'b0) begin
            errors++;
            $display("FAIL digit_handshakes: got %0d ev=%b want 3 0", hs_cnt - hs0, echo_valid);
        end
        checks++;
        if (bcd_out !== 16'h0123 || bin_out !== 14'd123 || count !== 4'd3) begin
            errors++;
            $display("FAIL digit_value: got bcd=%h bin=%0d cnt=%0d want 0123 123 3", bcd_out, bin_out, count);
        end
    endtask

    task automatic test_full();
        bit ev;
        logic [7:0] ch;
        int hs0;
        pulse_clr();
        hs0 = hs_cnt;
        press_echo(4'd9, 1'b1, ev, ch);
        press_echo(4'd8, 1'b1, ev, ch);
        press_echo(4'd7, 1'b1, ev, ch);
        checks++;
        if (full !== 1'b0) begin
            errors++;
            $display("FAIL full_early: got %b want 0", full);
        end
        press_echo(4'd6, 1'b1, ev, ch);
        checks++;
        if (full !== 1'b1 || count !== 4'd4) begin
            errors++;
            $display("FAIL full_set: got full=%b cnt=%0d want 1 4", full, count);
        end
        press_echo(4'd5, 1'b1, ev, ch);
        checks++;
        if (ev !== 1'b0 || hs_cnt - hs0 !== 4) begin
            errors++;
            $display("FAIL full_no_echo: got ev=%b hs=%0d want 0 4", ev, hs_cnt - hs0);
        end
        checks++;
        if (bcd_out !== 16'h9876 || bin_out !== 14'd9876) begin
            errors++;
            $display("FAIL full_value: got bcd=%h bin=%0d want 9876 9876", bcd_out, bin_out);
        end
    endtask

    task automatic test_enter();
        bit ev;
        logic [7:0] ch;
        pulse_clr();
        press_echo(4'd4, 1'b1, ev, ch);
        press_echo(4'd2, 1'b1, ev, ch);
        enter = 1'b1;
        tick();
        enter = 1'b0;
        checks++;
        if (operand_valid !== 1'b1 || operand_bin !== 14'd42) begin
            errors++;
            $display("FAIL enter_deliver: got v=%b op=%0d want 1 42", operand_valid, operand_bin);
        end
        checks++;
        if (count !== 4'd0 || bcd_out !== 16'h0 || bin_out !== 14'd0) begin
            errors++;
            $display("FAIL enter_clear: got cnt=%0d bcd=%h bin=%0d want 0 0 0", count, bcd_out, bin_out);
        end
        tick();
        checks++;
        if (operand_valid !== 1'b0) begin
            errors++;
            $display("FAIL enter_pulse_width: got %b want 0", operand_valid);
        end
        repeat (10) tick();
        checks++;
        if (operand_bin !== 14'd42) begin
            errors++;
            $display("FAIL enter_hold: got %0d want 42", operand_bin);
        end
    endtask

    task automatic test_pending_enter();
        int hs0;
        pulse_clr();
        hs0 = hs_cnt;
        digit_in = 4'd3;
        digit_valid = 1'b1;
        tick();
        checks++;
        if (echo_valid !== 1'b1 || echo_char !== 8'h33) begin
            errors++;
            $display("FAIL pend_echo: got ev=%b ch=%h want 1 33", echo_valid, echo_char);
        end
        digit_valid = 1'b0;
        tick();
        digit_in = 4'd4;
        digit_valid = 1'b1;
        tick();
        digit_valid = 1'b0;
        enter = 1'b1;
        tick();
        enter = 1'b0;
        tick();
        checks++;
        if (echo_valid !== 1'b1 || echo_char !== 8'h33 || count !== 4'd1 || operand_valid !== 1'b0) begin
            errors++;
            $display("FAIL pend_wait: got ev=%b ch=%h cnt=%0d v=%b want 1 33 1 0", echo_valid, echo_char, count, operand_valid);
        end
        echo_ready = 1'b1;
        tick();
        echo_ready = 1'b0;
        checks++;
        if (operand_valid !== 1'b1 || operand_bin !== 14'd3 || echo_valid !== 1'b0 || count !== 4'd0) begin
            errors++;
            $display("FAIL pend_deliver: got v=%b op=%0d ev=%b cnt=%0d want 1 3 0 0", operand_valid, operand_bin, echo_valid, count);
        end
        tick();
        checks++;
        if (operand_valid !== 1'b0 || hs_cnt - hs0 !== 1) begin
            errors++;
            $display("FAIL pend_after: got v=%b hs=%0d want 0 1", operand_valid, hs_cnt - hs0);
        end
    endtask

    task automatic test_clr_and_collision();
        pulse_clr();
        digit_in = 4'd8;
        digit_valid = 1'b1;
        tick();
        checks++;
        if (echo_valid !== 1'b1 || count !== 4'd1) begin
            errors++;
            $display("FAIL clr_setup: got ev=%b cnt=%0d want 1 1", echo_valid, count);
        end
        digit_valid = 1'b0;
        clr = 1'b1;
        tick();
        clr = 1'b0;
        checks++;
        if (echo_valid !== 1'b0 || count !== 4'd0 || bcd_out !== 16'h0 || operand_valid !== 1'b0 || operand_bin !== 14'd3) begin
            errors++;
            $display("FAIL clr_echo: got ev=%b cnt=%0d bcd=%h v=%b op=%0d want 0 0 0 0 3", echo_valid, count, bcd_out, operand_valid, operand_bin);
        end
        digit_in = 4'd7;
        digit_valid = 1'b1;
        enter = 1'b1;
        tick();
        enter = 1'b0;
        checks++;
        if (operand_valid !== 1'b1 || operand_bin !== 14'd0 || count !== 4'd0) begin
            errors++;
            $display("FAIL collide_deliver: got v=%b op=%0d cnt=%0d want 1 0 0", operand_valid, operand_bin, count);
        end
        tick();
        digit_valid = 1'b0;
        tick();
        checks++;
        if (count !== 4'd0 || echo_valid !== 1'b0 || bcd_out !== 16'h0) begin
            errors++;
            $display("FAIL collide_drop: got cnt=%0d ev=%b bcd=%h want 0 0 0", count, echo_valid, bcd_out);
        end
    endtask

    initial begin
        test_reset();
        test_digits();
        test_full();
        test_enter();
        test_pending_enter();
        test_clr_and_collision();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
